// File: rtl/encoder_8to3_stream_if.sv
// encoder_8to3_stream_if: vector-in / code-out valid-ready channels of the streaming 8-to-3 encoder
interface encoder_8to3_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_code, out_last
  );
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_code, out_last
  );
endinterface

// File: rtl/encoder_8to3_stream.sv
// encoder_8to3_stream: emits the index of every set bit of a vector, one per beat; ENC_DESCEND_EN selects highest-first order
module encoder_8to3_stream (
  input logic                   clk,
  input logic                   rst_n,
  encoder_8to3_stream_if.slave  s
);
  logic [7:0] pend_q, pend_d;
  logic [2:0] code;
  logic       fire_in, fire_out;
  // index of the next bit to emit; later loop iterations take priority
  always_comb begin
    code = '0;
`ifdef ENC_DESCEND_EN
    for (int i = 0; i < 8; i++) if (pend_q[i]) code = 3'(i);
`else
    for (int i = 7; i >= 0; i--) if (pend_q[i]) code = 3'(i);
`endif
  end
  assign s.out_valid = |pend_q;
  assign s.out_code  = code;
  assign s.out_last  = s.out_valid && ((pend_q & (pend_q - 8'd1)) == 8'd0);
  assign s.in_ready  = !s.out_valid || (s.out_ready && s.out_last);
  assign fire_in     = s.in_valid && s.in_ready;
  assign fire_out    = s.out_valid && s.out_ready;
  // a load can only coincide with the final beat, so it simply replaces pend
  always_comb pend_d = fire_in ? s.in_vec : fire_out ? (pend_q & ~(8'd1 << code)) : pend_q;
  // pending-bit register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
endmodule

// File: tb/tb_encoder_8to3_stream.sv
// tb_encoder_8to3_stream: scoreboard bench for the streaming 8-to-3 encoder
module tb_encoder_8to3_stream;
  typedef struct packed {logic [2:0] code; logic last;} exp_t;
  logic clk = 0, rst_n = 0, mon_en = 0, toggle_en = 0;
  int tests = 0, fails = 0, beats = 0, cyc = 0, c1, c2;
  exp_t sb[$];
  encoder_8to3_stream_if bus ();
  encoder_8to3_stream dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1 bus.out_ready = toggle_en ? !bus.out_ready : 1'b1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void push_exp(input logic [7:0] v);
    int n = $countones(v), k = 0, i;
    for (int j = 0; j < 8; j++) begin
`ifdef ENC_DESCEND_EN
      i = 7 - j;
`else
      i = j;
`endif
      if (v[i]) begin
        k++;
        sb.push_back('{code: 3'(i), last: (k == n)});
      end
    end
  endfunction
  task automatic send(input logic [7:0] v, output int acc);
    int t = 0;
    bus.in_valid = 1;
    bus.in_vec = v;
    acc = -1;
    while (t < 100) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = cyc;
        break;
      end
      t++;
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    else begin
      @(posedge clk);
      push_exp(v);
    end
    #1 bus.in_valid = 0;
    bus.in_vec = 8'hA5;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drain", sb.size(), 0);
    check("idle_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) if (mon_en && rst_n) begin
    check("valid", bus.out_valid, sb.size() != 0);
    check("in_ready", bus.in_ready, sb.size() == 0 || (bus.out_ready && sb[0].last));
    if (sb.size() != 0) begin
      check("code", bus.out_code, sb[0].code);
      check("last", bus.out_last, sb[0].last);
      if (bus.out_ready) begin
        void'(sb.pop_front());
        beats++;
      end
    end
  end
  initial begin
    bus.in_valid = 0;
    bus.in_vec = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_code", bus.out_code, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1;
    mon_en = 1;
    send(8'b0010_0100, c1);
    drain();
    beats = 0;
    send(8'h00, c1);
    repeat (3) @(negedge clk);
    check("zero_beats", beats, 0);
    check("zero_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    toggle_en = 1;
    beats = 0;
    send(8'hFF, c1);
    drain();
    check("ff_beats", beats, 8);
    toggle_en = 0;
    @(posedge clk);
    #1;
    send(8'h01, c1);
    send(8'h80, c2);
    drain();
    check("b2b_gap", c2 - c1, 1);
    send(8'h0F, c1);
    @(posedge clk);
    #2 rst_n = 0;
    sb.delete();
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_last", bus.out_last, 0);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    beats = 0;
    send(8'h10, c1);
    drain();
    check("post_rst_beats", beats, 1);
    for (int sel = 0; sel < 8; sel++) begin
      logic [7:0] dec;
      dec = 8'd1 << sel;
      beats = 0;
      send(dec, c1);
      drain();
      check("loop_beats", beats, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/encoder_8to3_stream.md
# encoder_8to3_stream

Streaming 8-to-3 encoder, the inverse of the 3-to-8 decoder. Accepts an 8-bit vector and emits, one per output handshake, the 3-bit index of every set bit, lowest index first. The last index of a vector is flagged. It converts a bank of request or flag lines back into the binary select codes the decoder side consumes, with valid/ready flow control on both ends.

## Interface
Parameters:
- None; widths are fixed at 8 in and 3 out.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector this cycle
- in_vec  input  8  vector to encode; bit i maps to code i
- out_valid  output  1  out_code/out_last are valid
- out_ready  input  1  consumer accepts the current code
- out_code  output  3  binary index of the current set bit
- out_last  output  1  current code is the final one for this vector

## Operation
- State register `pend[7:0]` holds bits not yet emitted. There are two states:
  - IDLE: `pend == 0`.
  - EMIT: `pend != 0`.
- Outputs are combinational from `pend`:
  - `out_valid = |pend`.
  - `out_code` = index of the lowest set bit of `pend`.
  - `out_last = (pend has exactly one bit set)`.
- `in_ready = (pend == 0) || (out_valid && out_ready && out_last)`. This allows a new vector to load on the same edge the last code is consumed.
- Input handshake: `in_valid && in_ready`.
  - `pend` loads `in_vec`.
  - A zero vector is accepted and discarded. `pend` stays 0, nothing is emitted, and in_ready stays 1.
- Output handshake: `out_valid && out_ready` clears the emitted bit in `pend`.
- Simultaneous last-beat handshake and input handshake: the load wins, so `pend <= in_vec`.
- If out_ready is low, `pend` is held. out_code and out_last stay stable while out_valid is high.
- A vector with N set bits produces exactly N output beats. Codes are strictly increasing, and only the Nth beat has out_last=1.
- in_vec is sampled only on the accepting edge. Later changes to in_vec have no effect.

## Timing
- Reset (rst_n low, asynchronous): `pend = 0`. Outputs are out_valid=0, out_code=0, out_last=0, in_ready=1.
- Reset asserted mid-vector: the remaining codes are dropped immediately.
- Reset deassertion is synchronised externally. The first accept can occur on the first rising edge with rst_n high.
- Latency: a vector accepted at edge k gives its first code valid after edge k (combinational from `pend`).
- Throughput: one code per cycle while out_ready=1. There are no idle cycles between vectors when in_valid is held.
- Vector 8'hFF with out_ready=1 takes 8 cycles: codes 0..7, out_last on code 7.

## Configuration
- Macro `ENC_DESCEND_EN`, defined:
  - Emission order is highest set bit first.
  - out_code = index of the highest set bit of `pend`.
  - out_last is unchanged (single bit remaining).
- Macro undefined: lowest-first order, as described above.
- All handshake, reset and latency rules are identical in both builds.

## Test plan
- Reset and basic load:
  - Reset, then apply in_vec=8'b0010_0100 with in_valid=1 and out_ready=1.
  - Expect out_code 2 (last=0), then 5 (last=1), then out_valid=0.
  - With `ENC_DESCEND_EN`, expect 5 then 2.
- Zero vector:
  - Apply in_vec=8'h00, accepted with in_ready=1.
  - Expect no out_valid pulse and in_ready to remain 1.
- Full vector under backpressure:
  - Apply in_vec=8'hFF with out_ready toggling 1,0,1,0…
  - Expect codes 0..7 each held stable during stalls, exactly 8 beats, out_last only on code 7.
  - Expect in_ready=0 until the final handshake.
- Back-to-back vectors:
  - Apply 8'h01 then 8'h80 with in_valid held high and out_ready=1.
  - Expect code 0 (last) and code 7 (last) on consecutive cycles.
  - Expect in_ready high on both accepting edges.
- Async reset mid-vector:
  - Load 8'h0F, consume code 0, then pulse rst_n low between clock edges.
  - Expect out_valid=0 immediately and in_ready=1.
  - After release, load 8'h10 and expect a single code 4, last=1.
- Decoder loopback:
  - For sel=0..7, feed the 3-to-8 decoder output into in_vec.
  - Expect a single beat with out_code==sel and out_last=1 for each.
